bf_bank_regmap: RTL
===================

// Module: bf_bank_regmap
// PURPOSE
//  Blackfin async-memory register file; generalises the ADC capture register map to N ping-pong banks.
//  Tracks which capture banks are full, points the Blackfin at the oldest unread bank and takes its ack.
//  Counts overruns, stretches a soft-reset pulse and exposes the ADC write address.
//  Sits between the EBIU pins (top level drives the tristate) and the ADC capture/bank-fill logic.
// PARAMETERS
//  DATA_W        16       Blackfin data bus width
//  ADDR_W        16       Blackfin address bits decoded (word offsets)
//  NUM_BANKS     2        capture banks, 2..16
//  BANK_W        1        clog2(NUM_BANKS); log2 of NUM_BANKS, min 1
//  PTR_HI_BASE   16'h2030 pointer MSW for bank 0; bank k reads PTR_HI_BASE+k
//  RST_PULSE_LEN 4        softReset high time in clocks, >=1
//  OVR_W         8        overrun counter width, <=DATA_W
//  VERSION       16'h0200 value of read-only ID register
// PORTS
//  BF_I_clk        in   1        Blackfin SCLK domain clock
//  I_rst           in   1        sync active-high reset
//  BF_I_addr       in   ADDR_W   word address within chip select
//  BF_I_wdata      in   DATA_W   write data from pad
//  BF_O_rdata      out  DATA_W   read data to pad
//  BF_O_rdataOE    out  1        pad output enable
//  BF_I_bankSelect in   1        chip select, active high
//  BF_I_are        in   1        read strobe, active high
//  BF_I_awe        in   1        write strobe, active high
//  ADC_I_addr      in   16       current ADC write address
//  I_fillDone      in   1        1-clk pulse: bank I_fillBank is full
//  I_fillBank      in   BANK_W   index of bank just filled
//  softReset       out  1        soft reset to FPGA capture logic
//  dataRdyLED      out  1        oldest-unread bank ready
//  O_read          out  1        1-clk pulse: Blackfin acked bank O_ackBank
//  O_ackBank       out  BANK_W   bank index acked (valid with O_read)
//  O_overrun       out  1        sticky: overrun count nonzero
// BEHAVIOUR
//  Reset: pending=0, rdBank=0, ovrCnt=0, scratch=0, ackErr=0, rstCnt=0, O_read=0, softReset=0.
//  Map (word offsets), R=read-only, W=write-action:
//   0x0 PTR_LO R: 0x0000 | 0x1 PTR_HI R: PTR_HI_BASE+rdBank
//   0x2 ACK W/R: read 0 | 0x4 STATUS R: [0]=pending[rdBank], [1]=ackErr, [2]=O_overrun,
//   [7:4]=rdBank, [15:8]=pending (zero-pad) | 0x6 SOFT_RST W: read {15'b0,softReset}
//   0x8 CUR_WADDR R: ADC_I_addr | 0xA OVR_CNT R / W clears ovrCnt and ackErr
//   0xC SCRATCH R/W | 0xE ID R: VERSION
//   Writes to R registers are ignored.
//  Read path: combinational; OE = are & cs & ~awe & addr decoded; unmapped address -> OE=0, rdata=0.
//  Write commit: once per strobe, on rising edge of (awe&cs), using addr/wdata sampled that cycle.
//   A strobe held N cycles commits once.
//  Fill: I_fillDone sets pending[I_fillBank].
//   If the bit is already set, ovrCnt++ (saturates at all-ones).
//  ACK commit, any wdata:
//   pending[rdBank]=1 -> clear it; O_read=1 next clk, O_ackBank=rdBank; rdBank=(rdBank+1)%NUM_BANKS.
//   pending[rdBank]=0 -> no state change except ackErr<=1; O_read stays 0.
//  Fill and ACK of the same bank in the same clk: ack completes, bank stays pending, no overrun.
//  dataRdyLED = pending[rdBank], registered view (1 clk after the cause).
//  SOFT_RST commit with wdata!=0: rstCnt=RST_PULSE_LEN; softReset=(rstCnt!=0); decrement per clk.
//   A new write during a pulse reloads the counter. softReset does not reset this block.
//  I_rst mid-pulse or mid-strobe: everything returns to reset values next clk.
//   An in-progress strobe does not commit after reset releases unless a new rising edge occurs.
// TESTING
//  Reset, then read 0x1 and 0xE -> 0x2030 and VERSION; read 0x4 -> 0x0000; OE only while are&cs.
//  Fill bank0, read STATUS -> 0x0101; ACK -> O_read 1 clk with O_ackBank=0; PTR_HI -> 0x2031.
//  Hold awe 5 clks on ACK with banks 0,1 pending -> exactly one O_read; rdBank=1.
//  Fill bank1 twice without ack -> OVR_CNT=1, O_overrun=1; write 0xA -> 0, O_overrun=0.
//  ACK with nothing pending -> no O_read, STATUS[1]=1; fill+ack same bank same clk -> bank still pending.
//  Write 0x6=1 -> softReset high exactly 4 clks; rewrite at clk 2 -> pulse extends; I_rst kills it.

Source files
------------

// File: rtl/bf_bank_regmap.sv
// Blackfin async-memory register file for N ping-pong ADC capture banks.
// Tracks full banks, points the host at the oldest unread one, counts overruns and stretches soft reset.
module bf_bank_regmap #(
  parameter int              DATA_W        = 16,
  parameter int              ADDR_W        = 16,
  parameter int              NUM_BANKS     = 2,
  parameter int              BANK_W        = 1,
  parameter logic [15:0]     PTR_HI_BASE   = 16'h2030,
  parameter int              RST_PULSE_LEN = 4,
  parameter int              OVR_W         = 8,
  parameter logic [15:0]     VERSION       = 16'h0200
) (
  input  logic                BF_I_clk,
  input  logic                I_rst,
  input  logic [ADDR_W-1:0]   BF_I_addr,
  input  logic [DATA_W-1:0]   BF_I_wdata,
  output logic [DATA_W-1:0]   BF_O_rdata,
  output logic                BF_O_rdataOE,
  input  logic                BF_I_bankSelect,
  input  logic                BF_I_are,
  input  logic                BF_I_awe,
  input  logic [15:0]         ADC_I_addr,
  input  logic                I_fillDone,
  input  logic [BANK_W-1:0]   I_fillBank,
  output logic                softReset,
  output logic                dataRdyLED,
  output logic                O_read,
  output logic [BANK_W-1:0]   O_ackBank,
  output logic                O_overrun
);

  localparam int RC_W = $clog2(RST_PULSE_LEN + 1);

  localparam logic [ADDR_W-1:0] A_PTR_LO = ADDR_W'(4'h0);
  localparam logic [ADDR_W-1:0] A_PTR_HI = ADDR_W'(4'h1);
  localparam logic [ADDR_W-1:0] A_ACK    = ADDR_W'(4'h2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4'h4);
  localparam logic [ADDR_W-1:0] A_SRST   = ADDR_W'(4'h6);
  localparam logic [ADDR_W-1:0] A_WADDR  = ADDR_W'(4'h8);
  localparam logic [ADDR_W-1:0] A_OVR    = ADDR_W'(4'hA);
  localparam logic [ADDR_W-1:0] A_SCR    = ADDR_W'(4'hC);
  localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(4'hE);

  logic [NUM_BANKS-1:0] pending_q, pending_d;
  logic [BANK_W-1:0]    rd_bank_q, rd_bank_d, rd_bank_nxt;
  logic [BANK_W-1:0]    ack_bank_q, ack_bank_d;
  logic [OVR_W-1:0]     ovr_cnt_q, ovr_cnt_d;
  logic [DATA_W-1:0]    scratch_q, scratch_d;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic                 ack_err_q, ack_err_d;
  logic                 o_read_q, o_read_d;
  logic                 led_q, led_d;
  logic                 strobe_prev_q, strobe_prev_d;

  logic        strobe, commit, ack_ok, fill_ok, fill_is_acked;
  logic        wr_ack, wr_srst, wr_ovr, wr_scr;
  logic [15:0] pend_pad;
  logic [15:0] status;
  logic [DATA_W-1:0] rd_mux;
  logic        hit;

  // A write commits only on the rising edge of the qualified strobe.
  assign strobe  = BF_I_awe & BF_I_bankSelect;
  assign commit  = strobe & ~strobe_prev_q;
  assign wr_ack  = commit && (BF_I_addr == A_ACK);
  assign wr_srst = commit && (BF_I_addr == A_SRST);
  assign wr_ovr  = commit && (BF_I_addr == A_OVR);
  assign wr_scr  = commit && (BF_I_addr == A_SCR);

  assign ack_ok        = wr_ack && pending_q[rd_bank_q];
  assign fill_ok       = I_fillDone && (int'(I_fillBank) < NUM_BANKS);
  assign fill_is_acked = ack_ok && (I_fillBank == rd_bank_q);
  assign rd_bank_nxt   = (rd_bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : rd_bank_q + 1'b1;

  always_comb begin
    pending_d     = pending_q;
    rd_bank_d     = rd_bank_q;
    ack_bank_d    = ack_bank_q;
    ovr_cnt_d     = ovr_cnt_q;
    scratch_d     = scratch_q;
    ack_err_d     = ack_err_q;
    rst_cnt_d     = rst_cnt_q;
    o_read_d      = 1'b0;
    strobe_prev_d = strobe;

    if (wr_ack) begin
      if (ack_ok) begin
        pending_d[rd_bank_q] = 1'b0;
        o_read_d             = 1'b1;
        ack_bank_d           = rd_bank_q;
        rd_bank_d            = rd_bank_nxt;
      end else begin
        ack_err_d = 1'b1;
      end
    end

    if (wr_ovr) begin
      ovr_cnt_d = '0;
      ack_err_d = 1'b0;
    end

    // A fill landing on the bank being acked the same clock refills it; not an overrun.
    if (fill_ok) begin
      if (pending_q[I_fillBank] && !fill_is_acked && (ovr_cnt_d != '1))
        ovr_cnt_d = ovr_cnt_d + 1'b1;
      pending_d[I_fillBank] = 1'b1;
    end

    if (wr_scr)
      scratch_d = BF_I_wdata;

    if (wr_srst && (BF_I_wdata != '0))
      rst_cnt_d = RC_W'(RST_PULSE_LEN);
    else if (rst_cnt_q != '0)
      rst_cnt_d = rst_cnt_q - 1'b1;

    led_d = pending_d[rd_bank_d];
  end

  always_ff @(posedge BF_I_clk) begin
    if (I_rst) begin
      pending_q     <= '0;
      rd_bank_q     <= '0;
      ack_bank_q    <= '0;
      ovr_cnt_q     <= '0;
      scratch_q     <= '0;
      ack_err_q     <= 1'b0;
      rst_cnt_q     <= '0;
      o_read_q      <= 1'b0;
      led_q         <= 1'b0;
      // Tracking the live strobe keeps a strobe held across reset from committing.
      strobe_prev_q <= strobe;
    end else begin
      pending_q     <= pending_d;
      rd_bank_q     <= rd_bank_d;
      ack_bank_q    <= ack_bank_d;
      ovr_cnt_q     <= ovr_cnt_d;
      scratch_q     <= scratch_d;
      ack_err_q     <= ack_err_d;
      rst_cnt_q     <= rst_cnt_d;
      o_read_q      <= o_read_d;
      led_q         <= led_d;
      strobe_prev_q <= strobe_prev_d;
    end
  end

  assign softReset  = (rst_cnt_q != '0);
  assign O_overrun  = (ovr_cnt_q != '0);
  assign O_read     = o_read_q;
  assign O_ackBank  = ack_bank_q;
  assign dataRdyLED = led_q;

  assign pend_pad = 16'(pending_q);
  assign status   = {pend_pad[7:0], 4'(rd_bank_q), 1'b0, O_overrun, ack_err_q, pending_q[rd_bank_q]};

  always_comb begin
    rd_mux = '0;
    hit    = 1'b1;
    case (BF_I_addr)
      A_PTR_LO: rd_mux = '0;
      A_PTR_HI: rd_mux = DATA_W'(PTR_HI_BASE) + DATA_W'(rd_bank_q);
      A_ACK:    rd_mux = '0;
      A_STATUS: rd_mux = DATA_W'(status);
      A_SRST:   rd_mux = DATA_W'(softReset);
      A_WADDR:  rd_mux = DATA_W'(ADC_I_addr);
      A_OVR:    rd_mux = DATA_W'(ovr_cnt_q);
      A_SCR:    rd_mux = scratch_q;
      A_ID:     rd_mux = DATA_W'(VERSION);
      default:  hit    = 1'b0;
    endcase
  end

  assign BF_O_rdataOE = BF_I_are & BF_I_bankSelect & ~BF_I_awe & hit;
  assign BF_O_rdata   = BF_O_rdataOE ? rd_mux : '0;

endmodule
